// File: rtl/iter_shifter_pkg.sv
// Shared definitions for iter_shifter: op encodings and FSM state encodings.
// Optional 4-bit stepping is enabled by defining ITER_SHIFTER_STEP4_EN.
package iter_shifter_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step: one combinational shift step of 1 bit, or 4 bits when by4=1.
// Used by iter_shifter for each SHIFT cycle; op encoding matches iter_shifter_pkg.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int N = 16,
  parameter int O = 2
) (
  input  logic [N-1:0] in,
  input  logic [O-1:0] op,
  input  logic         by4,
  output logic [N-1:0] out
);

  always_comb begin
    out = in;
    if (by4) begin
      case (op)
        OP_ROL:  out = {in[N-5:0], in[N-1:N-4]};
        OP_SLL:  out = {in[N-5:0], 4'b0000};
        OP_SRA:  out = {{4{in[N-1]}}, in[N-1:4]};
        default: out = {4'b0000, in[N-1:4]};
      endcase
    end else begin
      case (op)
        OP_ROL:  out = {in[N-2:0], in[N-1]};
        OP_SLL:  out = {in[N-2:0], 1'b0};
        OP_SRA:  out = {in[N-1], in[N-1:1]};
        default: out = {1'b0, in[N-1:1]};
      endcase
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter with valid/ready request and response ports.
// Define ITER_SHIFTER_STEP4_EN to take 4-bit steps while at least 4 positions remain.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_in,
  input  logic [C-1:0] req_cnt,
  input  logic [O-1:0] req_op,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_out,
  output logic         busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid holds its payload stable until that edge; ready never
  // depends combinationally on valid.

  logic [1:0]   state;
  logic [N-1:0] data_q;
  logic [O-1:0] op_q;
  logic [C-1:0] rem_q;
  logic         by4;
  logic [C-1:0] step;
  logic [N-1:0] step_out;

`ifdef ITER_SHIFTER_STEP4_EN
  assign by4 = (rem_q >= C'(4));
`else
  assign by4 = 1'b0;
`endif

  // Step never exceeds rem: 4 only when rem>=4, and rem>=1 throughout SHIFT.
  assign step = by4 ? C'(4) : C'(1);

  shift_step #(.N(N), .O(O)) u_step (
    .in  (data_q),
    .op  (op_q),
    .by4 (by4),
    .out (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_q <= '0;
      op_q   <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            data_q <= req_in;
            op_q   <= req_op;
            rem_q  <= req_cnt;
            state  <= (req_cnt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q <= step_out;
          rem_q  <= rem_q - step;
          if (rem_q == step) state <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign busy       = (state == ST_SHIFT) || (state == ST_DONE);
  assign resp_out   = data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: vector table, multi-cycle corner cases, random soak.
// Expected latency follows ITER_SHIFTER_STEP4_EN when defined at compile time.
module tb_iter_shifter;

  localparam int N = 16;
  localparam int C = 4;
  localparam int O = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_in = '0;
  logic [C-1:0] req_cnt = '0;
  logic [O-1:0] req_op = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [N-1:0] resp_out;
  logic         busy;

  iter_shifter #(.N(N), .C(C), .O(O)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in     (req_in),
    .req_cnt    (req_cnt),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [N-1:0] exp_q[$];
  logic soak_on = 1'b0;
  logic mon_on  = 1'b0;

  typedef struct {
    logic [N-1:0] in;
    int           cnt;
    logic [1:0]   op;
    logic [N-1:0] exp_out;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full shift in one go using plain arithmetic.
  function automatic logic [N-1:0] model(input logic [N-1:0] x, input int c, input logic [1:0] op);
    case (op)
      2'b00:   return (c == 0) ? x : ((x << c) | (x >> (N - c)));
      2'b01:   return x << c;
      2'b10:   return $signed(x) >>> c;
      default: return x >> c;
    endcase
  endfunction

  function automatic int exp_lat(input int c);
`ifdef ITER_SHIFTER_STEP4_EN
    return c / 4 + c % 4 + 1;
`else
    return c + 1;
`endif
  endfunction

  // Called at #1 after a posedge with the unit idle; returns at #1 after the accept edge.
  task automatic send(input logic [N-1:0] d, input int c, input logic [1:0] op);
    int guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("req_ready_before_send", {31'b0, req_ready}, 32'd1);
    req_in    = d;
    req_cnt   = C'(c);
    req_op    = op;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge (1 = visible right after it) until resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_timeout: got no resp_valid after %0d cycles", lat);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL soak_unexpected_resp: got %0h expected none", resp_out);
      end else begin
        check("soak_resp_out", {16'b0, resp_out}, {16'b0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (soak_on) begin
      #1;
      resp_ready = ($urandom_range(0, 1) == 1);
    end
  end

  vec_t vecs[$];

  initial begin
    int lat;
    logic saw_valid;

    vecs.push_back('{16'h8001,  1, 2'b00, 16'h0003});
    vecs.push_back('{16'h8000, 15, 2'b10, 16'hFFFF});
    vecs.push_back('{16'hA0A0,  4, 2'b11, 16'h0A0A});
    vecs.push_back('{16'h1234,  0, 2'b01, 16'h1234});
    vecs.push_back('{16'h1234,  4, 2'b00, 16'h2341});
    vecs.push_back('{16'h8000, 15, 2'b00, 16'h4000});
    vecs.push_back('{16'h0001, 15, 2'b01, 16'h8000});
    vecs.push_back('{16'h7FFF, 15, 2'b10, 16'h0000});
    vecs.push_back('{16'hFFFF, 15, 2'b11, 16'h0001});
    vecs.push_back('{16'hF0F0,  5, 2'b10, 16'hFF87});
    vecs.push_back('{16'hABCD,  7, 2'b01, 16'hE680});
    vecs.push_back('{16'h5A5A,  3, 2'b11, 16'h0B4B});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'b0, req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_busy",       {31'b0, busy},       32'd0);
    check("rst_resp_out",   {16'b0, resp_out},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table, resp_ready held high
    resp_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].in, vecs[i].cnt, vecs[i].op);
      check("vec_busy_after_accept", {31'b0, busy}, 32'd1);
      wait_resp(lat);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].cnt));
      check($sformatf("vec%0d_resp_out", i), {16'b0, resp_out}, {16'b0, vecs[i].exp_out});
      check("vec_req_ready_done", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      check("vec_idle_after_handshake", {31'b0, req_ready}, 32'd1);
    end

    // Backpressure: response held 3 cycles, a second request ignored meanwhile
    resp_ready = 1'b0;
    send(16'hA0A0, 4, 2'b11);
    wait_resp(lat);
    req_in = 16'h0001; req_cnt = 4'd1; req_op = 2'b00; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_resp_out",   {16'b0, resp_out},   32'h0A0A);
      check("bp_req_ready",  {31'b0, req_ready},  32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_back_idle", {31'b0, req_ready}, 32'd1);
    check("bp_resp_dropped", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    check("bp_second_latency", lat, exp_lat(1));
    check("bp_second_out", {16'b0, resp_out}, 32'h0002);
    @(posedge clk); #1;

    // Reset during SHIFT drops the operation
    send(16'hFFFF, 8, 2'b11);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready",  {31'b0, req_ready},  32'd1);
    check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_busy",       {31'b0, busy},       32'd0);
    check("mid_rst_resp_out",   {16'b0, resp_out},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_resp", {31'b0, saw_valid}, 32'd0);
    send(16'h1234, 0, 2'b01);
    wait_resp(lat);
    check("post_rst_latency", lat, 1);
    check("post_rst_out", {16'b0, resp_out}, 32'h1234);
    @(posedge clk); #1;

    // Random soak with random backpressure
    mon_on  = 1'b1;
    soak_on = 1'b1;
    for (int t = 0; t < 150; t++) begin
      int guard;
      logic [N-1:0] d;
      int c;
      logic [1:0] op;
      d  = N'($urandom);
      c  = $urandom_range(0, N - 1);
      op = 2'($urandom_range(0, 3));
      req_in = d; req_cnt = C'(c); req_op = op; req_valid = 1'b1;
      guard = 0;
      forever begin
        @(negedge clk);
        if (req_ready) break;
        guard++;
        if (guard > 200) break;
      end
      if (guard > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL soak_accept_timeout: got req_ready=0 expected 1");
      end else begin
        exp_q.push_back(model(d, c, op));
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    soak_on = 1'b0;
    @(posedge clk); #2;
    resp_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("soak_queue_drained", exp_q.size(), 0);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
